// File: rtl/lane_shift_right_pipe.sv
// lane_shift_right_pipe
// Two-stage valid/ready pipeline that splits the data word into LANE_W-bit
// lanes and shifts each lane right by the unsigned amount held in the
// matching lane of the amount word. Logical mode zero-fills the lane.
// Arithmetic mode fills it with copies of the lane MSB. No bits ever move
// across a lane boundary.
// Stage 1 captures the operands. Stage 2 captures the shifted result, and
// the outputs are driven directly from stage 2. The ready path is purely
// combinational from out_ready, so the pipeline keeps one transfer per
// clock under continuous flow. When the consumer stalls, it holds at most
// two items.

module lane_shift_right_pipe #(
   parameter int NUM_BITS = 512,
   parameter int LANE_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NUM_BITS-1:0] dd,
   input  logic [NUM_BITS-1:0] aa,
   input  logic                arith,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NUM_BITS-1:0] shift
);

   localparam int NUM_LANES = NUM_BITS / LANE_W;

   // The lane width expressed at the same width as a lane's shift amount.
   // Any amount at or above it clears the lane entirely to the fill value.
   localparam logic [LANE_W-1:0] LANE_W_AMT = LANE_W'(LANE_W);

   logic                s1Valid_q;
   logic                s1Valid_d;
   logic [NUM_BITS-1:0] s1Dd_q;
   logic [NUM_BITS-1:0] s1Dd_d;
   logic [NUM_BITS-1:0] s1Aa_q;
   logic [NUM_BITS-1:0] s1Aa_d;
   logic                s1Arith_q;
   logic                s1Arith_d;

   logic                s2Valid_q;
   logic                s2Valid_d;
   logic [NUM_BITS-1:0] s2Shift_q;
   logic [NUM_BITS-1:0] s2Shift_d;

   logic                s2Free;
   logic                s1Free;
   logic                s1Load;
   logic                s1Advance;
   logic [NUM_BITS-1:0] laneResult;

   // Shifts a single lane. The lane is placed below a field of fill bits
   // before the shift, so the vacated upper positions automatically receive
   // the fill value. Amounts of LANE_W or more leave only the fill bits.
   function automatic logic [LANE_W-1:0] shiftLane(
      input logic [LANE_W-1:0] laneData,
      input logic [LANE_W-1:0] laneAmt,
      input logic              useArith
   );
      logic                  fillBit;
      logic [2*LANE_W-1:0]   extended;
      logic [LANE_W-1:0]     result;
      fillBit  = useArith & laneData[LANE_W-1];
      extended = {{LANE_W{fillBit}}, laneData} >> laneAmt;
      if (laneAmt >= LANE_W_AMT) begin
         result = {LANE_W{fillBit}};
      end else begin
         result = extended[LANE_W-1:0];
      end
      return result;
   endfunction

   // Handshake decisions: a stage is free when it is empty or when its
   // contents leave this cycle. in_ready therefore depends on out_ready
   // only through gates, and no registered feedback path exists.
   assign s2Free    = !s2Valid_q || out_ready;
   assign s1Free    = !s1Valid_q || s2Free;
   assign s1Load    = in_valid && s1Free;
   assign s1Advance = s1Valid_q && s2Free;

   assign in_ready  = s1Free;
   assign out_valid = s2Valid_q;
   assign shift     = s2Shift_q;

   // Per-lane right shift of the stage-1 operands. One arith flag, sampled
   // with the operands, applies to every lane of that transfer.
   always_comb begin
      laneResult = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         laneResult[k*LANE_W +: LANE_W] = shiftLane(s1Dd_q[k*LANE_W +: LANE_W],
                                                    s1Aa_q[k*LANE_W +: LANE_W],
                                                    s1Arith_q);
      end
   end

   // Next-state for both stages. A stage's valid is set when data arrives
   // and cleared when its data leaves with nothing replacing it. Data
   // registers change only on a load, so a stalled output stays stable.
   always_comb begin
      s1Valid_d = s1Valid_q;
      s1Dd_d    = s1Dd_q;
      s1Aa_d    = s1Aa_q;
      s1Arith_d = s1Arith_q;
      s2Valid_d = s2Valid_q;
      s2Shift_d = s2Shift_q;

      if (s1Load) begin
         s1Valid_d = 1'b1;
         s1Dd_d    = dd;
         s1Aa_d    = aa;
         s1Arith_d = arith;
      end else if (s1Advance) begin
         s1Valid_d = 1'b0;
      end

      if (s1Advance) begin
         s2Valid_d = 1'b1;
         s2Shift_d = laneResult;
      end else if (out_ready) begin
         s2Valid_d = 1'b0;
      end
   end

   // Stage-1 operand register. Reset discards anything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid_q <= 1'b0;
         s1Dd_q    <= '0;
         s1Aa_q    <= '0;
         s1Arith_q <= 1'b0;
      end else begin
         s1Valid_q <= s1Valid_d;
         s1Dd_q    <= s1Dd_d;
         s1Aa_q    <= s1Aa_d;
         s1Arith_q <= s1Arith_d;
      end
   end

   // Stage-2 result register. Its contents drive the outputs directly, so
   // asserting reset clears out_valid and shift immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2Valid_q <= 1'b0;
         s2Shift_q <= '0;
      end else begin
         s2Valid_q <= s2Valid_d;
         s2Shift_q <= s2Shift_d;
      end
   end

endmodule

// File: tb/tb_lane_shift_right_pipe.sv
// tb_lane_shift_right_pipe
// Drives the lane shifter with directed cases and random streams. Expected
// results come from an item queue that computes each lane shift with
// integer arithmetic, plus a simple latency and occupancy model.

module tb_lane_shift_right_pipe;

   localparam int NB = 512;
   localparam int LW = 8;
   localparam int NL = NB / LW;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [NB-1:0] dd;
   logic [NB-1:0] aa;
   logic          arith;
   logic          out_valid;
   logic          out_ready;
   logic [NB-1:0] shift;

   int vectors;
   int miscompares;
   int cycleNum;

   logic [NB-1:0] modelQ[$];
   int            modelCyc[$];

   logic          expValid;
   logic          expReady;
   logic          expAccept;
   logic [NB-1:0] expShift;
   logic          obsValid;
   logic          obsReady;
   logic [NB-1:0] obsShift;

   lane_shift_right_pipe #(.NUM_BITS(NB), .LANE_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dd        (dd),
      .aa        (aa),
      .arith     (arith),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .shift     (shift)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference lane shift. Each lane is read as a plain integer. In
   // arithmetic mode the lane is first reinterpreted as signed, so shifting
   // the integer reproduces sign fill.
   function automatic logic [NB-1:0] refShift(input logic [NB-1:0] d,
                                              input logic [NB-1:0] a,
                                              input logic ar);
      logic [NB-1:0] r;
      int v;
      int s;
      int q;
      r = '0;
      for (int k = 0; k < NL; k++) begin
         v = int'(d[k*LW +: LW]);
         s = int'(a[k*LW +: LW]);
         if (ar && v >= (1 << (LW-1))) v = v - (1 << LW);
         if (s >= LW) q = (v < 0) ? -1 : 0;
         else         q = v >>> s;
         r[k*LW +: LW] = q[LW-1:0];
      end
      return r;
   endfunction

   // Returns a fully random wide word.
   function automatic logic [NB-1:0] randWide();
      logic [NB-1:0] r;
      for (int i = 0; i < NB/32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   // Returns random shift amounts. Small amounts are favoured, and some
   // lanes receive amounts of LW or more.
   function automatic logic [NB-1:0] randAmt();
      logic [NB-1:0] r;
      for (int k = 0; k < NL; k++) begin
         if ($urandom_range(0, 3) == 0) r[k*LW +: LW] = LW'($urandom_range(LW, (1 << LW) - 1));
         else                           r[k*LW +: LW] = LW'($urandom_range(0, LW - 1));
      end
      return r;
   endfunction

   // Applies one cycle of stimulus at the falling edge, then samples the
   // DUT. It also advances the model: the oldest item becomes visible two
   // cycles after it is accepted, and input is refused only when two items
   // are held and the consumer is stalled.
   task automatic applyStimulus(input logic iv, input logic [NB-1:0] d,
                                input logic [NB-1:0] a, input logic ar,
                                input logic ordy);
      @(negedge clk);
      in_valid  = iv;
      dd        = d;
      aa        = a;
      arith     = ar;
      out_ready = ordy;
      #1;
      expValid  = (modelQ.size() > 0) && (cycleNum >= modelCyc[0] + 2);
      expShift  = expValid ? modelQ[0] : '0;
      expReady  = !((modelQ.size() == 2) && !ordy);
      expAccept = iv && expReady;
      obsValid  = out_valid;
      obsReady  = in_ready;
      obsShift  = shift;
      if (expValid && ordy) begin
         void'(modelQ.pop_front());
         void'(modelCyc.pop_front());
      end
      if (expAccept) begin
         modelQ.push_back(refShift(d, a, ar));
         modelCyc.push_back(cycleNum);
      end
      cycleNum++;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dd        = '0;
      aa        = '0;
      arith     = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset out_valid: got %0b expected 0", out_valid);
      end
      vectors++;
      if (shift !== '0) begin
         miscompares++;
         $display("FAIL reset shift: got %h expected 0", shift);
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset in_ready: got %0b expected 1", in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [NB-1:0] d;
      logic [NB-1:0] a;
      logic [NB-1:0] want;
      logic          ar;
      for (int c = 0; c < 5; c++) begin
         d = '0; a = '0; want = '0; ar = 1'b0;
         case (c)
            0: begin d[7:0] = 8'b1000_0110; a[7:0] = 8'd1; want[7:0] = 8'b0100_0011; end
            1: begin d[311:304] = 8'b1001_0000; a[311:304] = 8'd4; want[311:304] = 8'b0000_1001; end
            2: begin d[511:504] = 8'hF0; a[511:504] = 8'd9; want[511:504] = 8'h00; end
            3: begin d[511:504] = 8'hF0; a[511:504] = 8'd9; ar = 1'b1; want[511:504] = 8'hFF; end
            default: begin d[511:504] = 8'hF0; a[511:504] = 8'd2; ar = 1'b1; want[511:504] = 8'hFC; end
         endcase
         applyStimulus(1'b1, d, a, ar, 1'b1);
         for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
            vectors++;
            if (obsValid !== expValid) begin
               miscompares++;
               $display("FAIL directed%0d out_valid cyc%0d: got %0b expected %0b", c, i, obsValid, expValid);
            end
            if (expValid) begin
               vectors++;
               if (obsShift !== want) begin
                  miscompares++;
                  $display("FAIL directed%0d shift: got %h expected %h", c, obsShift, want);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 7; i++) begin
         if (i < 4) applyStimulus(1'b1, randWide(), randAmt(), 1'($urandom_range(0, 1)), 1'b1);
         else       applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
         vectors++;
         if (obsReady !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b in_ready cyc%0d: got %0b expected 1", i, obsReady);
         end
         vectors++;
         if (obsValid !== expValid) begin
            miscompares++;
            $display("FAIL b2b out_valid cyc%0d: got %0b expected %0b", i, obsValid, expValid);
         end
         if (expValid) begin
            vectors++;
            if (obsShift !== expShift) begin
               miscompares++;
               $display("FAIL b2b shift cyc%0d: got %h expected %h", i, obsShift, expShift);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [NB-1:0] items[3];
      logic [NB-1:0] amts[3];
      logic          ars[3];
      int            idx;
      idx = 0;
      for (int i = 0; i < 3; i++) begin
         items[i] = randWide();
         amts[i]  = randAmt();
         ars[i]   = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 14; i++) begin
         if (idx < 3) applyStimulus(1'b1, items[idx], amts[idx], ars[idx], (i >= 6));
         else         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
         if (expAccept) idx++;
         vectors++;
         if (obsReady !== expReady) begin
            miscompares++;
            $display("FAIL bp in_ready cyc%0d: got %0b expected %0b", i, obsReady, expReady);
         end
         vectors++;
         if (obsValid !== expValid) begin
            miscompares++;
            $display("FAIL bp out_valid cyc%0d: got %0b expected %0b", i, obsValid, expValid);
         end
         if (expValid) begin
            vectors++;
            if (obsShift !== expShift) begin
               miscompares++;
               $display("FAIL bp shift cyc%0d: got %h expected %h", i, obsShift, expShift);
            end
         end
      end
   endtask

   task automatic test_random();
      logic          iv;
      logic [NB-1:0] d;
      logic [NB-1:0] a;
      logic          ar;
      logic          ordy;
      logic          holding;
      holding = 1'b0;
      iv = 1'b0; d = '0; a = '0; ar = 1'b0;
      for (int i = 0; i < 310; i++) begin
         if (i >= 300) begin
            iv = 1'b0;
            ordy = 1'b1;
         end else begin
            if (!holding) begin
               iv = ($urandom_range(0, 9) < 7);
               d  = randWide();
               a  = randAmt();
               ar = 1'($urandom_range(0, 1));
            end
            ordy = ($urandom_range(0, 9) < 6);
         end
         applyStimulus(iv, d, a, ar, ordy);
         holding = iv && !expAccept;
         vectors++;
         if (obsReady !== expReady) begin
            miscompares++;
            $display("FAIL rand in_ready cyc%0d: got %0b expected %0b", i, obsReady, expReady);
         end
         vectors++;
         if (obsValid !== expValid) begin
            miscompares++;
            $display("FAIL rand out_valid cyc%0d: got %0b expected %0b", i, obsValid, expValid);
         end
         if (expValid) begin
            vectors++;
            if (obsShift !== expShift) begin
               miscompares++;
               $display("FAIL rand shift cyc%0d: got %h expected %h", i, obsShift, expShift);
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      applyStimulus(1'b1, randWide(), randAmt(), 1'b0, 1'b0);
      applyStimulus(1'b1, randWide(), randAmt(), 1'b1, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      vectors++;
      if (obsValid !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset preload out_valid: got %0b expected 1", obsValid);
      end
      vectors++;
      if (obsReady !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset preload in_ready: got %0b expected 0", obsReady);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset out_valid: got %0b expected 0", out_valid);
      end
      vectors++;
      if (shift !== '0) begin
         miscompares++;
         $display("FAIL midreset shift: got %h expected 0", shift);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      modelQ.delete();
      modelCyc.delete();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
         vectors++;
         if (obsValid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset stale out_valid cyc%0d: got %0b expected 0", i, obsValid);
         end
      end
   endtask

   // Runs each scenario in sequence and prints the summary line.
   initial begin
      vectors     = 0;
      miscompares = 0;
      cycleNum    = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
